// File: rtl/exc_collect_pkg.sv
// Shared types and constants for the exception collector: ExcCode values, slot layout,
// FSM encoding and the memory-alignment fault helper.
package exc_collect_pkg;

    localparam logic [4:0] ExcNone = 5'd0;
    localparam logic [4:0] ExcAdEL = 5'd4;
    localparam logic [4:0] ExcAdES = 5'd5;
    localparam logic [4:0] ExcSys  = 5'd8;
    localparam logic [4:0] ExcBp   = 5'd9;
    localparam logic [4:0] ExcRI   = 5'd10;
    localparam logic [4:0] ExcOv   = 5'd12;

    localparam logic [31:0] ExcVectorDefault = 32'hBFC0_0380;

    typedef enum logic {
        StRun   = 1'b0,
        StRedir = 1'b1
    } exc_state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] code;
        logic       bd;
        logic       eret;
    } exc_slot_t;

    // size: 0=byte, 1=half, 2=word; bytes never fault
    function automatic logic mem_misaligned(input logic [1:0] size, input logic [1:0] addr);
        logic fault;
        fault = 1'b0;
        unique case (size)
            2'd1:    fault = addr[0];
            2'd2:    fault = (addr != 2'b00);
            default: fault = 1'b0;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/exc_collect_if.sv
// Pipeline/cp0 side signals of the exception collector. The master drives the pipeline
// inputs and consumes the cp0/redirect outputs; the slave is exc_collect itself.
interface exc_collect_if;
    logic [31:0] pc_F;
    logic        stall_D;
    logic        stall_E;
    logic        stall_M;
    logic        ri_D;
    logic        sys_D;
    logic        brk_D;
    logic        eret_D;
    logic        bd_D;
    logic        ov_E;
    logic        load_E;
    logic        store_E;
    logic [1:0]  size_E;
    logic [1:0]  addr_E;
    logic        req;
    logic [31:0] epc;
    logic [5:0]  HWInt_in;
    logic [5:0]  HWInt;
    logic [4:0]  ExcCode;
    logic        bd;
    logic        EXLClr;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output pc_F, stall_D, stall_E, stall_M, ri_D, sys_D, brk_D, eret_D, bd_D,
        output ov_E, load_E, store_E, size_E, addr_E, req, epc, HWInt_in,
        input  HWInt, ExcCode, bd, EXLClr, flush, redirect_valid, redirect_pc
    );

    modport slave (
        input  pc_F, stall_D, stall_E, stall_M, ri_D, sys_D, brk_D, eret_D, bd_D,
        input  ov_E, load_E, store_E, size_E, addr_E, req, epc, HWInt_in,
        output HWInt, ExcCode, bd, EXLClr, flush, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/exc_slot_reg.sv
// One pipeline exception slot (valid, code, bd, eret). Flush beats stall; a bubble is
// loaded when the upstream stage is stalled but this one is not.
module exc_slot_reg
    import exc_collect_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      i_stall,
    input  logic      i_bubble,
    input  logic      i_flush,
    input  exc_slot_t i_slot,
    output exc_slot_t o_slot
);

    exc_slot_t r_slot;

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_slot <= '0;
        end else if (!i_stall) begin
            r_slot <= i_bubble ? exc_slot_t'('0) : i_slot;
        end
    end

    assign o_slot = r_slot;

endmodule

// File: rtl/exc_collect.sv
// Collects exception causes along D/E/M, drives cp0 and issues a one-cycle fetch redirect.
// Optional macro EXC_INT_SYNC_EN adds a SYNC_STAGES-deep synchronizer on HWInt_in.
module exc_collect
    import exc_collect_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = ExcVectorDefault
`ifdef EXC_INT_SYNC_EN
    ,
    parameter int unsigned SYNC_STAGES = 2
`endif
) (
    input logic          clk,
    input logic          reset,
    exc_collect_if.slave bus
);

    exc_slot_t   w_f_slot;
    exc_slot_t   w_d_next;
    exc_slot_t   w_e_next;
    exc_slot_t   w_d_slot;
    exc_slot_t   w_e_slot;
    exc_slot_t   w_m_slot;
    logic        w_exl_clr;
    logic        w_flush;
    logic        w_redirect_valid;
    logic        w_unused_pc;
    exc_state_e  r_state;
    logic [31:0] r_pc_nxt;

    assign w_unused_pc = ^bus.pc_F[31:2];

    // Each stage keeps the oldest cause; later causes only fill an empty code.
    always_comb begin
        w_f_slot       = '0;
        w_f_slot.valid = 1'b1;
        if (bus.pc_F[1:0] != 2'b00) w_f_slot.code = ExcAdEL;

        w_d_next    = w_d_slot;
        w_d_next.bd = bus.bd_D;
        if (w_d_next.code == ExcNone) begin
            if (bus.ri_D)       w_d_next.code = ExcRI;
            else if (bus.sys_D) w_d_next.code = ExcSys;
            else if (bus.brk_D) w_d_next.code = ExcBp;
        end
        w_d_next.eret = bus.eret_D && (w_d_next.code == ExcNone);

        w_e_next = w_e_slot;
        if (w_e_next.code == ExcNone) begin
            if (bus.ov_E) begin
                w_e_next.code = ExcOv;
            end else if ((bus.load_E || bus.store_E) && mem_misaligned(bus.size_E, bus.addr_E)) begin
                w_e_next.code = bus.load_E ? ExcAdEL : ExcAdES;
            end
        end
        if (w_e_next.code != ExcNone) w_e_next.eret = 1'b0;
    end

    exc_slot_reg u_slot_d (
        .clk      (clk),
        .reset    (reset),
        .i_stall  (bus.stall_D),
        .i_bubble (1'b0),
        .i_flush  (w_flush),
        .i_slot   (w_f_slot),
        .o_slot   (w_d_slot)
    );

    exc_slot_reg u_slot_e (
        .clk      (clk),
        .reset    (reset),
        .i_stall  (bus.stall_E),
        .i_bubble (bus.stall_D),
        .i_flush  (w_flush),
        .i_slot   (w_d_next),
        .o_slot   (w_e_slot)
    );

    exc_slot_reg u_slot_m (
        .clk      (clk),
        .reset    (reset),
        .i_stall  (bus.stall_M),
        .i_bubble (bus.stall_E),
        .i_flush  (w_flush),
        .i_slot   (w_e_next),
        .o_slot   (w_m_slot)
    );

    assign w_exl_clr        = w_m_slot.valid && w_m_slot.eret && !bus.req;
    assign w_redirect_valid = (r_state == StRedir);
    // Flush is held through the redirect cycle to kill the wrong-path fetch.
    assign w_flush          = bus.req || w_exl_clr || w_redirect_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= StRun;
            r_pc_nxt <= '0;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (bus.req || w_exl_clr) begin
                        r_state  <= StRedir;
                        r_pc_nxt <= bus.req ? EXC_VECTOR : bus.epc;
                    end
                end
                StRedir: r_state <= StRun;
            endcase
        end
    end

    assign bus.ExcCode        = w_m_slot.valid ? w_m_slot.code : ExcNone;
    assign bus.bd             = w_m_slot.valid && w_m_slot.bd;
    assign bus.EXLClr         = w_exl_clr;
    assign bus.flush          = w_flush;
    assign bus.redirect_valid = w_redirect_valid;
    assign bus.redirect_pc    = r_pc_nxt;

`ifdef EXC_INT_SYNC_EN
    logic [5:0] r_hwint_sync [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hwint_sync <= '{default: '0};
        end else begin
            r_hwint_sync[0] <= bus.HWInt_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_hwint_sync[i] <= r_hwint_sync[i-1];
            end
        end
    end

    assign bus.HWInt = r_hwint_sync[SYNC_STAGES-1];
`else
    assign bus.HWInt = bus.HWInt_in;
`endif

endmodule
